// File: rtl/mem_access_ctrl.sv
// Load/store sequencer between execute stage and a combinational-read word memory.
// Sub-word stores are read-modify-write; loads are lane-extracted and extended.
module mem_access_ctrl #(
   parameter int MEM_WORDS = 256
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_we,
   output logic        mem_re,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

   localparam logic [31:0] MEM_WORDS_U = 32'(MEM_WORDS);

   state_t      state_q, state_d;
   logic        we_q, we_d;
   logic [1:0]  size_q, size_d;
   logic        uns_q, uns_d;
   logic [1:0]  lane_q, lane_d;
   logic [15:0] wdata_q, wdata_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic [31:0] rsp_rdata_q, rsp_rdata_d;
   logic        rsp_err_q, rsp_err_d;

   logic        accept;
   logic        req_err;
   logic [7:0]  rd_byte;
   logic [15:0] rd_half;
   logic [31:0] load_val;
   logic [31:0] merged;

   assign accept = req_valid && (state_q == IDLE);

   always_comb begin
      req_err = (req_size == 2'b11)
             || (req_size == 2'b01 && req_addr[0])
             || (req_size == 2'b10 && req_addr[1:0] != 2'b00)
             || ({2'b00, req_addr[31:2]} >= MEM_WORDS_U);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         we_q        <= 1'b0;
         size_q      <= 2'b00;
         uns_q       <= 1'b0;
         lane_q      <= 2'b00;
         wdata_q     <= 16'h0;
         mem_addr_q  <= 32'h0;
         mem_wdata_q <= 32'h0;
         rsp_rdata_q <= 32'h0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         we_q        <= we_d;
         size_q      <= size_d;
         uns_q       <= uns_d;
         lane_q      <= lane_d;
         wdata_q     <= wdata_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   // RD with a store latched can only be a sub-word store; word stores skip RD.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (req_err)                          state_d = RESP;
               else if (!req_we || req_size != 2'b10) state_d = RD;
               else                                   state_d = WR;
            end
         end
         RD:      state_d = we_q ? WR : RESP;
         WR:      state_d = RESP;
         RESP:    if (rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      rd_byte = mem_rdata[{lane_q, 3'b000} +: 8];
      rd_half = mem_rdata[{lane_q[1], 4'b0000} +: 16];
      case (size_q)
         2'b00:   load_val = {{24{~uns_q & rd_byte[7]}}, rd_byte};
         2'b01:   load_val = {{16{~uns_q & rd_half[15]}}, rd_half};
         default: load_val = mem_rdata;
      endcase
      merged = mem_rdata;
      if (size_q == 2'b00) merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
      else                 merged[{lane_q[1], 4'b0000} +: 16] = wdata_q;
   end

   always_comb begin
      we_d        = we_q;
      size_d      = size_q;
      uns_d       = uns_q;
      lane_d      = lane_q;
      wdata_d     = wdata_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               we_d        = req_we;
               size_d      = req_size;
               uns_d       = req_unsigned;
               lane_d      = req_addr[1:0];
               wdata_d     = req_wdata[15:0];
               rsp_rdata_d = 32'h0;
               rsp_err_d   = req_err;
               // Memory-side registers only move when an access will follow.
               if (!req_err) begin
                  mem_addr_d = {2'b00, req_addr[31:2]};
                  if (req_we && req_size == 2'b10) mem_wdata_d = req_wdata;
               end
            end
         end
         RD: begin
            if (we_q) mem_wdata_d = merged;
            else      rsp_rdata_d = load_val;
         end
         default: ;
      endcase
   end

   always_comb begin
      req_ready = (state_q == IDLE);
      rsp_valid = (state_q == RESP);
      mem_re    = (state_q == RD);
      mem_we    = (state_q == WR);
      rsp_rdata = rsp_rdata_q;
      rsp_err   = rsp_err_q;
      mem_addr  = mem_addr_q;
      mem_wdata = mem_wdata_q;
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed vector table, hand-written stall/reset
// sequences, then random traffic against a word-array reference model.
module tb_mem_access_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready, req_we, req_unsigned;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic        rsp_valid, rsp_ready, rsp_err;
   logic [31:0] rsp_rdata;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_we, mem_re;

   always #5 clk = ~clk;

   mem_access_ctrl #(.MEM_WORDS(256)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_size(req_size), .req_unsigned(req_unsigned),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata)
   );

   // Data memory seen by the DUT, and the reference model's view of it.
   logic [31:0] tb_mem  [256];
   logic [31:0] ref_mem [256];

   assign mem_rdata = (mem_re && !mem_we && mem_addr < 32'd256) ? tb_mem[mem_addr[7:0]] : 32'h0;
   always @(posedge clk) if (mem_we && !mem_re && mem_addr < 32'd256) tb_mem[mem_addr[7:0]] <= mem_wdata;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Reference: plain arithmetic on the word array, updated for stores.
   task automatic ref_op(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rdata, output logic err, output int lat,
                         output logic [31:0] wexp);
      int unsigned idx, off, bits;
      logic [31:0] w, low_mask, mask, v;
      idx  = addr / 4;
      off  = addr % 4;
      bits = (size == 2'd0) ? 8 : 16;
      low_mask = (32'h1 << bits) - 32'h1;
      err  = (size == 2'd3) || (size == 2'd1 && (off % 2) != 0)
          || (size == 2'd2 && off != 0) || (idx >= 256);
      rdata = 32'h0;
      wexp  = 32'h0;
      if (err) begin
         lat = 1;
      end else if (!we) begin
         w = ref_mem[idx];
         if (size == 2'd2) begin
            rdata = w;
         end else begin
            v = (w >> (8 * off)) & low_mask;
            if (!uns && v[bits-1]) v = v | ~low_mask;
            rdata = v;
         end
         lat = 2;
      end else if (size == 2'd2) begin
         ref_mem[idx] = wdata;
         wexp = wdata;
         lat = 2;
      end else begin
         w = ref_mem[idx];
         mask = low_mask << (8 * off);
         ref_mem[idx] = (w & ~mask) | ((wdata << (8 * off)) & mask);
         wexp = ref_mem[idx];
         lat = 3;
      end
   endtask

   // Issue one request with rsp_ready high; report response, latency and strobe activity.
   task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rdata, output logic err, output int lat,
                         output int nre, output int nwe, output logic [31:0] wa,
                         output logic [31:0] wd, output int overlap);
      req_we = we; req_size = size; req_unsigned = uns;
      req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
      lat = 0; nre = 0; nwe = 0; overlap = 0; wa = 32'hx; wd = 32'hx;
      while (1) begin
         @(posedge clk); #1;
         lat++;
         if (lat == 1) req_valid = 1'b0;
         if (mem_re) nre++;
         if (mem_we) begin nwe++; wa = mem_addr; wd = mem_wdata; end
         if (mem_re && mem_we) overlap++;
         if (rsp_valid || lat >= 10) break;
      end
      rdata = rsp_rdata;
      err   = rsp_err;
      $display("[TB] txn we=%0d size=%0d uns=%0d addr=0x%08h wdata=0x%08h -> rdata=0x%08h err=%0d lat=%0d",
               we, size, uns, addr, wdata, rdata, err, lat);
      @(posedge clk); #1;
   endtask

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
      int          exp_lat;
      int          exp_re;
      int          exp_we;
      logic [31:0] exp_wdata;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic we, input logic [1:0] size, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat,
                      input int exp_re, input int exp_we, input logic [31:0] exp_wdata);
      vec_t v;
      v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
      v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_lat = exp_lat;
      v.exp_re = exp_re; v.exp_we = exp_we; v.exp_wdata = exp_wdata;
      vecs.push_back(v);
   endtask

   initial begin
      logic [31:0] rd, wa, wd, e_rd, e_wd, held;
      logic        er, e_err;
      int          lat, nre, nwe, ovl, e_lat, cnt;
      logic        r_we, r_uns;
      logic [1:0]  r_size;
      logic [31:0] r_addr, r_wdata;

      for (int i = 0; i < 256; i++) begin tb_mem[i] = 32'h0; ref_mem[i] = 32'h0; end
      rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
      req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b1;

      #1;
      chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
      chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
      chk("rst_rsp_rdata", rsp_rdata, 32'h0);
      chk("rst_rsp_err",   {31'h0, rsp_err}, 32'h0);
      chk("rst_mem_addr",  mem_addr, 32'h0);
      chk("rst_mem_wdata", mem_wdata, 32'h0);
      chk("rst_strobes",   {30'h0, mem_we, mem_re}, 32'h0);
      repeat (3) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      // we size uns addr wdata | rdata err lat re we wdata
      add(1, 2, 0, 32'h10,  32'hDEADBEEF, 32'h0,        0, 2, 0, 1, 32'hDEADBEEF);
      add(0, 2, 0, 32'h10,  32'h0,        32'hDEADBEEF, 0, 2, 1, 0, 32'h0);
      add(1, 2, 0, 32'h10,  32'h11223344, 32'h0,        0, 2, 0, 1, 32'h11223344);
      add(1, 0, 0, 32'h12,  32'h123456AA, 32'h0,        0, 3, 1, 1, 32'h11AA3344);
      add(0, 0, 0, 32'h12,  32'h0,        32'hFFFFFFAA, 0, 2, 1, 0, 32'h0);
      add(0, 0, 1, 32'h12,  32'h0,        32'h000000AA, 0, 2, 1, 0, 32'h0);
      add(0, 0, 0, 32'h11,  32'h0,        32'h00000033, 0, 2, 1, 0, 32'h0);
      add(1, 2, 0, 32'h10,  32'h80017FFF, 32'h0,        0, 2, 0, 1, 32'h80017FFF);
      add(0, 1, 0, 32'h12,  32'h0,        32'hFFFF8001, 0, 2, 1, 0, 32'h0);
      add(0, 1, 0, 32'h10,  32'h0,        32'h00007FFF, 0, 2, 1, 0, 32'h0);
      add(0, 1, 1, 32'h12,  32'h0,        32'h00008001, 0, 2, 1, 0, 32'h0);
      add(0, 1, 0, 32'h13,  32'h0,        32'h0,        1, 1, 0, 0, 32'h0);
      add(0, 2, 0, 32'h12,  32'h0,        32'h0,        1, 1, 0, 0, 32'h0);
      add(0, 3, 0, 32'h10,  32'h0,        32'h0,        1, 1, 0, 0, 32'h0);
      add(0, 2, 0, 32'h400, 32'h0,        32'h0,        1, 1, 0, 0, 32'h0);
      add(1, 0, 0, 32'h400, 32'hFF,       32'h0,        1, 1, 0, 0, 32'h0);
      add(1, 1, 0, 32'h11,  32'h1234,     32'h0,        1, 1, 0, 0, 32'h0);
      add(1, 1, 0, 32'h3FE, 32'h1234BEEF, 32'h0,        0, 3, 1, 1, 32'hBEEF0000);
      add(0, 2, 0, 32'h3FC, 32'h0,        32'hBEEF0000, 0, 2, 1, 0, 32'h0);
      add(1, 0, 0, 32'h3FC, 32'h77,       32'h0,        0, 3, 1, 1, 32'hBEEF0077);
      add(0, 0, 0, 32'h3FF, 32'h0,        32'hFFFFFFBE, 0, 2, 1, 0, 32'h0);

      foreach (vecs[i]) begin
         ref_op(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata,
                e_rd, e_err, e_lat, e_wd);
         chk($sformatf("v%0d_ready", i), {31'h0, req_ready}, 32'h1);
         do_req(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata,
                rd, er, lat, nre, nwe, wa, wd, ovl);
         chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
         chk($sformatf("v%0d_err", i), {31'h0, er}, {31'h0, vecs[i].exp_err});
         chk($sformatf("v%0d_lat", i), lat, vecs[i].exp_lat);
         chk($sformatf("v%0d_re_pulses", i), nre, vecs[i].exp_re);
         chk($sformatf("v%0d_we_pulses", i), nwe, vecs[i].exp_we);
         chk($sformatf("v%0d_overlap", i), ovl, 0);
         if (vecs[i].exp_we != 0) begin
            chk($sformatf("v%0d_wdata", i), wd, vecs[i].exp_wdata);
            chk($sformatf("v%0d_waddr", i), wa, vecs[i].addr >> 2);
         end
      end

      // Backpressure: stall a load response for 5 cycles with a competing request.
      ref_op(1, 2, 0, 32'h20, 32'h01020304, e_rd, e_err, e_lat, e_wd);
      do_req(1, 2, 0, 32'h20, 32'h01020304, rd, er, lat, nre, nwe, wa, wd, ovl);
      chk("bp_setup_wdata", wd, 32'h01020304);
      ref_op(0, 2, 0, 32'h10, 32'h0, e_rd, e_err, e_lat, e_wd);
      rsp_ready = 1'b0;
      req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h10; req_valid = 1'b1;
      @(posedge clk); #1; req_valid = 1'b0;
      @(posedge clk); #1;
      chk("bp_first_valid", {31'h0, rsp_valid}, 32'h1);
      chk("bp_first_rdata", rsp_rdata, e_rd);
      held = rsp_rdata;
      cnt = 0;
      for (int i = 0; i < 5; i++) begin
         if (i == 1) begin
            req_we = 1'b1; req_size = 2'b10; req_addr = 32'h20; req_wdata = 32'hCAFEF00D;
            req_valid = 1'b1;
         end
         @(posedge clk); #1;
         chk($sformatf("bp_hold_valid_%0d", i), {31'h0, rsp_valid}, 32'h1);
         chk($sformatf("bp_hold_rdata_%0d", i), rsp_rdata, held);
         chk($sformatf("bp_hold_ready_%0d", i), {31'h0, req_ready}, 32'h0);
         if (mem_we || mem_re) cnt++;
      end
      req_valid = 1'b0;
      chk("bp_no_access_during_stall", cnt, 0);
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_released", {31'h0, rsp_valid}, 32'h0);
      cnt = 0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         if (rsp_valid || mem_we || mem_re) cnt++;
      end
      chk("bp_single_response", cnt, 0);
      $display("[TB] txn backpressure load addr=0x00000010 -> rdata=0x%08h held=5", held);

      // Reset asserted in the RD cycle of a sub-word store.
      req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0; req_addr = 32'h21;
      req_wdata = 32'h55; req_valid = 1'b1;
      @(posedge clk); #1; req_valid = 1'b0;
      chk("rstmid_in_rd", {31'h0, mem_re}, 32'h1);
      #1 rst_n = 1'b0;
      #1;
      chk("rstmid_strobes", {30'h0, mem_we, mem_re}, 32'h0);
      chk("rstmid_rsp_valid", {31'h0, rsp_valid}, 32'h0);
      chk("rstmid_req_ready", {31'h0, req_ready}, 32'h1);
      chk("rstmid_mem_addr", mem_addr, 32'h0);
      @(negedge clk) rst_n = 1'b1;
      cnt = 0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         if (rsp_valid || mem_we || mem_re || !req_ready) cnt++;
      end
      chk("rstmid_quiet_after", cnt, 0);
      $display("[TB] txn reset during sub-word store addr=0x00000021 dropped");
      ref_op(0, 2, 0, 32'h20, 32'h0, e_rd, e_err, e_lat, e_wd);
      do_req(0, 2, 0, 32'h20, 32'h0, rd, er, lat, nre, nwe, wa, wd, ovl);
      chk("rstmid_next_rdata", rd, e_rd);
      chk("rstmid_next_lat", lat, 2);

      // Random traffic against the reference model.
      for (int k = 0; k < 200; k++) begin
         r_we    = 1'($urandom_range(0, 1));
         r_uns   = 1'($urandom_range(0, 1));
         r_size  = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
         r_wdata = $urandom;
         case ($urandom_range(0, 9))
            0:       r_addr = $urandom;
            1, 2:    r_addr = 32'($urandom_range(248, 255)) * 4 + 32'($urandom_range(0, 3));
            default: r_addr = 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3));
         endcase
         ref_op(r_we, r_size, r_uns, r_addr, r_wdata, e_rd, e_err, e_lat, e_wd);
         do_req(r_we, r_size, r_uns, r_addr, r_wdata, rd, er, lat, nre, nwe, wa, wd, ovl);
         chk($sformatf("r%0d_rdata", k), rd, e_rd);
         chk($sformatf("r%0d_err", k), {31'h0, er}, {31'h0, e_err});
         chk($sformatf("r%0d_lat", k), lat, e_lat);
         chk($sformatf("r%0d_re_pulses", k), nre, (!e_err && (!r_we || r_size != 2'b10)) ? 1 : 0);
         chk($sformatf("r%0d_we_pulses", k), nwe, (!e_err && r_we) ? 1 : 0);
         chk($sformatf("r%0d_overlap", k), ovl, 0);
         if (!e_err && r_we) chk($sformatf("r%0d_wdata", k), wd, e_wd);
      end

      for (int i = 0; i < 256; i++) begin
         if (i < 16 || i >= 248) chk($sformatf("final_mem_%0d", i), tb_mem[i], ref_mem[i]);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Load/store sequencer between the execute stage and the word-addressed, combinational-read data memory. Accepts one byte/halfword/word request at a time over a valid/ready handshake and drives the memory's address, write data and read/write strobes from registers. Sub-word stores are done as read-modify-write, and loads are lane-extracted and sign- or zero-extended. Returns one response per request, holding it until the consumer takes it.

## Interface
- MEM_WORDS, 256: number of 32-bit words in the data memory; word index range 0..MEM_WORDS-1.

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- req_unsigned  in  1  loads: 1 zero-extend, 0 sign-extend; ignored for stores
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer takes response
- rsp_rdata  out  32  load result; 0 for stores and errors
- rsp_err  out  1  misaligned, out-of-range or illegal size; no memory access performed
- mem_addr  out  32  word index = req_addr[31:2]
- mem_wdata  out  32  full word to write
- mem_we  out  1  memory write strobe
- mem_re  out  1  memory read strobe
- mem_rdata  in  32  memory read data, combinational from mem_addr

## Operation
- States: IDLE, RD, WR, RESP.
- IDLE: req_ready=1. On req_valid&req_ready, latch all req_* fields and classify:
  - error if size==11, or half with addr[0]!=0, or word with addr[1:0]!=0, or addr[31:2] >= MEM_WORDS -> RESP with rsp_err=1
  - load -> RD
  - word store -> WR
  - byte/half store -> RD
- RD: mem_re=1, mem_we=0. Capture mem_rdata at cycle end.
  - Load: extract the lane and go to RESP.
  - Sub-word store: merge and go to WR.
- WR: mem_we=1, mem_re=0, with mem_wdata = full word (word store) or merged word (sub-word), then RESP.
- RESP: rsp_valid=1 with rsp_rdata and rsp_err stable. Go to IDLE on rsp_ready; otherwise hold.
- Lanes are little-endian.
  - Byte lane k = addr[1:0] occupies bits [8k+7:8k].
  - Half lane addr[1]=0 is [15:0]; addr[1]=1 is [31:16].
- Extension: sign-extend from bit 7 (byte) or bit 15 (half) unless req_unsigned=1. Word loads are passed through.
- Merge: replace only the addressed lane of the captured word with req_wdata's low byte/half. Other lanes are unchanged.
- Strobe rules:
  - mem_we and mem_re are never high together; the memory outputs 0 when both strobes are equal.
  - Each strobe is high for exactly one cycle per access.
  - mem_addr and mem_wdata are registered and stable for the whole strobe cycle.
- Between accesses: strobes are 0, and mem_addr/mem_wdata hold their last values.
- Requests presented while not in IDLE are ignored (req_ready=0). There is no queuing.

## Timing
- Reset values: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_addr=0, mem_wdata=0, mem_we=0, mem_re=0.
- Cycle 0 is the accept cycle.
- Latency to first rsp_valid:
  - error: 1 cycle (RESP in cycle 1)
  - load: 2 cycles (RD in cycle 1)
  - word store: 2 cycles (WR in cycle 1)
  - sub-word store: 3 cycles (RD cycle 1, WR cycle 2)
- Back-to-back throughput: with rsp_ready tied high, a new request can be accepted the cycle after RESP. Loads therefore sustain 1 request per 3 cycles.
- Reset asserted mid-operation:
  - All outputs go to reset values immediately and asynchronously; the in-flight request is dropped with no response.
  - Reset during WR leaves that memory word unspecified.
- rsp_valid is never deasserted without rsp_ready. rsp_rdata and rsp_err do not change while rsp_valid=1.

## Test plan
- Word store then word load: store addr 0x10, data 0xDEADBEEF, then load addr 0x10.
  - Store: mem_we one cycle with mem_addr=4, mem_wdata=0xDEADBEEF.
  - Load: rsp_rdata=0xDEADBEEF, rsp_valid 2 cycles after accept.
- Byte store read-modify-write: word 4 holds 0x11223344; store byte 0xAA at addr 0x12.
  - Expect mem_re in cycle 1, then mem_we in cycle 2 with mem_wdata=0x11AA3344.
  - Signed byte load from 0x12 returns 0xFFFFFFAA; unsigned returns 0x000000AA.
- Half load: word 4 = 0x80017FFF.
  - Signed half at 0x12 returns 0xFFFF8001.
  - Signed half at 0x10 returns 0x00007FFF.
- Errors: each of these gives rsp_err=1 one cycle after accept, rsp_rdata=0, and no mem_we/mem_re pulse:
  - half at 0x13
  - word at 0x12
  - size 11
  - word at 0x400 (MEM_WORDS=256)
- Backpressure: hold rsp_ready=0 for 5 cycles on a load.
  - rsp_valid and rsp_rdata stay stable and req_ready stays 0.
  - A req_valid presented during the stall is not accepted.
  - Release gives exactly one response.
- Reset during sub-word store: assert rst_n=0 in the RD cycle.
  - Strobes drop immediately, there is no response, and req_ready=1 after release.
  - The next load completes normally.
